// File: rtl/pipeline_ctrl_pkg.sv
// ============================================================================
// pipeline_ctrl_pkg : shared state encodings, HALT encoding, rs/rt fields
// Revision 1.0
// ============================================================================
`default_nettype none

package pipeline_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_STEP   = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_HALTED = 3'd4
    } state_t;

    localparam logic [31:0] HALT_INST = 32'hFFFF_FFFF;

    // Register field positions, shared with the decode stage
    localparam int RS_LSB = 21;
    localparam int RT_LSB = 16;

endpackage

`default_nettype wire

// File: rtl/pipeline_ctrl_hazard_detect.sv
// ============================================================================
// pipeline_ctrl_hazard_detect : combinational load-use hazard compare
// Revision 1.0
// ============================================================================
`default_nettype none

module pipeline_ctrl_hazard_detect
    import pipeline_ctrl_pkg::*;
#(
    parameter int REG_ADDR_BITS = 5,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     i_mem_read,
    input  logic [REG_ADDR_BITS-1:0] i_rt_addr,
    input  logic [DATA_WIDTH-1:0]    i_inst,
    output logic                     o_stall
);

    logic [REG_ADDR_BITS-1:0] w_rs;
    logic [REG_ADDR_BITS-1:0] w_rt;

    assign w_rs = i_inst[RS_LSB +: REG_ADDR_BITS];
    assign w_rt = i_inst[RT_LSB +: REG_ADDR_BITS];

    // $zero is never a real dependency
    assign o_stall = i_mem_read && (i_rt_addr != '0) &&
                     ((i_rt_addr == w_rs) || (i_rt_addr == w_rt));

endmodule

`default_nettype wire

// File: rtl/pipeline_ctrl.sv
// ============================================================================
// pipeline_ctrl : run/step/halt sequencer and load-use stall controller
// Revision 1.0
// ============================================================================
`default_nettype none

module pipeline_ctrl #(
    parameter int                      REG_ADDR_BITS = 5,
    parameter int                      DATA_WIDTH    = 32,
    parameter int                      CNT_WIDTH     = 32,
    parameter int                      DRAIN_CYCLES  = 4,
    parameter logic [DATA_WIDTH-1:0]   HALT_INST     = pipeline_ctrl_pkg::HALT_INST
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     run_req,
    input  logic                     step_req,
    input  logic                     pause_req,
    input  logic [DATA_WIDTH-1:0]    inst_in,
    input  logic                     ex_mem_read,
    input  logic [REG_ADDR_BITS-1:0] ex_rt_addr,
    output logic                     pipe_en,
    output logic                     pc_en,
    output logic                     if_id_en,
    output logic                     reset_control_buses,
    output logic                     halted,
    output logic                     busy,
    output logic [CNT_WIDTH-1:0]     cycle_count,
    output logic [CNT_WIDTH-1:0]     stall_count
);

    import pipeline_ctrl_pkg::*;

    localparam int                DRAIN_W    = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES - 1);

    state_t               r_state;
    state_t               w_next;
    logic [DRAIN_W-1:0]   r_drain;
    logic [CNT_WIDTH-1:0] r_cycle;
    logic [CNT_WIDTH-1:0] r_stall;
    logic                 w_stall;
    logic                 w_halt_id;
    logic                 w_stall_inc;
    logic                 w_drain_load;

    pipeline_ctrl_hazard_detect #(
        .REG_ADDR_BITS (REG_ADDR_BITS),
        .DATA_WIDTH    (DATA_WIDTH)
    ) u_hazard (
        .i_mem_read (ex_mem_read),
        .i_rt_addr  (ex_rt_addr),
        .i_inst     (inst_in),
        .o_stall    (w_stall)
    );

    assign w_halt_id = (inst_in == HALT_INST);

    always_comb begin
        w_next              = r_state;
        pipe_en             = 1'b0;
        pc_en               = 1'b0;
        if_id_en            = 1'b0;
        reset_control_buses = 1'b0;
        w_stall_inc         = 1'b0;
        w_drain_load        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (run_req)
                    w_next = ST_RUN;
                else if (step_req)
                    w_next = ST_STEP;
            end
            ST_RUN, ST_STEP: begin
                pipe_en = 1'b1;
                // A stall holds the HALT in ID, so the halt is only acted on once it clears
                if (w_stall) begin
                    reset_control_buses = 1'b1;
                    w_stall_inc         = 1'b1;
                    if (r_state == ST_STEP || pause_req)
                        w_next = ST_IDLE;
                end else if (w_halt_id) begin
                    reset_control_buses = 1'b1;
                    w_drain_load        = 1'b1;
                    w_next              = ST_DRAIN;
                end else begin
                    pc_en    = 1'b1;
                    if_id_en = 1'b1;
                    if (r_state == ST_STEP || pause_req)
                        w_next = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                pipe_en             = 1'b1;
                reset_control_buses = 1'b1;
                if (r_drain == '0)
                    w_next = ST_HALTED;
            end
            ST_HALTED: ;
            default: w_next = ST_IDLE;
        endcase
    end

    assign halted = (r_state == ST_HALTED);
    assign busy   = (r_state == ST_RUN) || (r_state == ST_STEP) || (r_state == ST_DRAIN);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_drain <= '0;
        end else begin
            r_state <= w_next;
            if (w_drain_load)
                r_drain <= DRAIN_LOAD;
            else if (r_state == ST_DRAIN && r_drain != '0)
                r_drain <= r_drain - DRAIN_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cycle <= '0;
            r_stall <= '0;
        end else begin
            if (pipe_en && (r_cycle != '1))
                r_cycle <= r_cycle + CNT_WIDTH'(1);
            if (w_stall_inc && (r_stall != '1))
                r_stall <= r_stall + CNT_WIDTH'(1);
        end
    end

    assign cycle_count = r_cycle;
    assign stall_count = r_stall;

endmodule

`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
// ============================================================================
// tb_pipeline_ctrl : scoreboard bench for pipeline_ctrl
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_pipeline_ctrl;

    // Output vector order: pipe_en, pc_en, if_id_en, bubble, halted, busy
    localparam logic [5:0] IDL = 6'b000000;
    localparam logic [5:0] ACT = 6'b111001;
    localparam logic [5:0] STL = 6'b100101;
    localparam logic [5:0] DRN = 6'b100101;
    localparam logic [5:0] HLT = 6'b000010;

    localparam logic [31:0] ADD  = 32'h0022_1820; // add $3,$1,$2
    localparam logic [31:0] HZR  = 32'h00A2_1820; // add $3,$5,$2
    localparam logic [31:0] HZT  = 32'h0025_1820; // add $3,$1,$5
    localparam logic [31:0] ZR   = 32'h0000_1820; // add $3,$0,$0
    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    typedef struct {
        string       nm;
        logic [5:0]  outs;
        logic [31:0] cyc;
        logic [31:0] stl;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        run_req, step_req, pause_req;
    logic [31:0] inst_in;
    logic        ex_mem_read;
    logic [4:0]  ex_rt_addr;
    logic        pipe_en, pc_en, if_id_en, reset_control_buses, halted, busy;
    logic [31:0] cycle_count, stall_count;

    exp_t        sb[$];
    exp_t        m_e;
    logic [5:0]  m_act;
    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] exp_cyc  = 0;
    logic [31:0] exp_stl  = 0;

    pipeline_ctrl dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .run_req             (run_req),
        .step_req            (step_req),
        .pause_req           (pause_req),
        .inst_in             (inst_in),
        .ex_mem_read         (ex_mem_read),
        .ex_rt_addr          (ex_rt_addr),
        .pipe_en             (pipe_en),
        .pc_en               (pc_en),
        .if_id_en            (if_id_en),
        .reset_control_buses (reset_control_buses),
        .halted              (halted),
        .busy                (busy),
        .cycle_count         (cycle_count),
        .stall_count         (stall_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            m_e   = sb.pop_front();
            m_act = {pipe_en, pc_en, if_id_en, reset_control_buses, halted, busy};
            n_assert++;
            if (m_act !== m_e.outs) begin
                n_fail++;
                $display("FAIL %s outputs: got %b expected %b", m_e.nm, m_act, m_e.outs);
            end
            n_assert++;
            if (cycle_count !== m_e.cyc) begin
                n_fail++;
                $display("FAIL %s cycle_count: got %0d expected %0d", m_e.nm, cycle_count, m_e.cyc);
            end
            n_assert++;
            if (stall_count !== m_e.stl) begin
                n_fail++;
                $display("FAIL %s stall_count: got %0d expected %0d", m_e.nm, stall_count, m_e.stl);
            end
        end
    end

    task automatic push(input string nm, input logic [5:0] outs, input logic stall_inc);
        exp_t e;
        e.nm   = nm;
        e.outs = outs;
        e.cyc  = exp_cyc;
        e.stl  = exp_stl;
        sb.push_back(e);
        if (outs[5]) exp_cyc = exp_cyc + 1;
        if (stall_inc) exp_stl = exp_stl + 1;
    endtask

    task automatic vec(input string nm, input logic run, input logic step, input logic pause,
                       input logic [31:0] inst, input logic mr, input logic [4:0] rt,
                       input logic [5:0] outs, input logic stall_inc);
        @(posedge clk);
        #1;
        run_req     = run;
        step_req    = step;
        pause_req   = pause;
        inst_in     = inst;
        ex_mem_read = mr;
        ex_rt_addr  = rt;
        push(nm, outs, stall_inc);
    endtask

    // Reset asserted 1 time unit after an edge so the check lands mid-cycle
    task automatic do_reset(input string nm);
        @(posedge clk);
        #1;
        reset_n     = 1'b0;
        run_req     = 1'b0;
        step_req    = 1'b0;
        pause_req   = 1'b0;
        inst_in     = ADD;
        ex_mem_read = 1'b0;
        ex_rt_addr  = '0;
        exp_cyc     = 0;
        exp_stl     = 0;
        push(nm, IDL, 1'b0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n     = 1'b0;
        run_req     = 1'b0;
        step_req    = 1'b0;
        pause_req   = 1'b0;
        inst_in     = ADD;
        ex_mem_read = 1'b0;
        ex_rt_addr  = '0;

        do_reset("reset");
        vec("idle",         0, 0, 0, ADD, 0, 5'd0, IDL, 0);
        vec("run_go",       1, 0, 0, ADD, 0, 5'd0, IDL, 0);
        for (int i = 0; i < 10; i++)
            vec("run_add",  0, 0, 0, ADD, 0, 5'd0, ACT, 0);
        vec("stall_rs",     0, 0, 0, HZR, 1, 5'd5, STL, 1);
        vec("resume",       0, 0, 0, HZR, 0, 5'd5, ACT, 0);
        vec("stall_rt",     0, 0, 0, HZT, 1, 5'd5, STL, 1);
        vec("r0_no_stall",  0, 0, 0, ZR,  1, 5'd0, ACT, 0);
        vec("addr_mismatch",0, 0, 0, ADD, 1, 5'd5, ACT, 0);
        vec("run_ign_step", 0, 1, 0, ADD, 0, 5'd0, ACT, 0);
        vec("pause",        0, 0, 1, ADD, 0, 5'd0, ACT, 0);
        vec("idle_after",   0, 0, 0, ADD, 0, 5'd0, IDL, 0);

        for (int i = 0; i < 3; i++) begin
            vec("step_req",  0, 1, 0, ADD, 0, 5'd0, IDL, 0);
            vec("step_exec", 0, 0, 0, ADD, 0, 5'd0, ACT, 0);
            vec("step_gap",  0, 0, 0, ADD, 0, 5'd0, IDL, 0);
            vec("step_gap",  0, 0, 0, ADD, 0, 5'd0, IDL, 0);
        end
        vec("step_req2",    0, 1, 0, ADD, 0, 5'd0, IDL, 0);
        vec("step_stall",   0, 0, 0, HZR, 1, 5'd5, STL, 1);
        vec("step_consumed",0, 0, 0, ADD, 0, 5'd0, IDL, 0);

        vec("run_and_step", 1, 1, 0, ADD, 0, 5'd0, IDL, 0);
        vec("run_wins",     0, 0, 0, ADD, 0, 5'd0, ACT, 0);
        vec("halt_hazard",  0, 0, 0, HALT, 1, 5'd31, STL, 1);
        vec("halt_id",      0, 0, 1, HALT, 0, 5'd0, DRN, 0);
        for (int i = 0; i < 4; i++)
            vec("drain",    1, 1, 0, ADD, 0, 5'd0, DRN, 0);
        for (int i = 0; i < 3; i++)
            vec("halted",   1, 1, 0, ADD, 0, 5'd0, HLT, 0);

        do_reset("reset_halted");
        vec("run2",         1, 0, 0, ADD, 0, 5'd0, IDL, 0);
        vec("run2_add",     0, 0, 0, ADD, 0, 5'd0, ACT, 0);
        vec("halt2",        0, 0, 0, HALT, 0, 5'd0, DRN, 0);
        vec("drain2",       0, 0, 0, ADD, 0, 5'd0, DRN, 0);
        vec("drain2",       0, 0, 0, ADD, 0, 5'd0, DRN, 0);
        do_reset("reset_mid_drain");
        vec("restart",      1, 0, 0, ADD, 0, 5'd0, IDL, 0);
        vec("restart_run",  0, 0, 0, ADD, 0, 5'd0, ACT, 0);
        vec("restart_run",  0, 0, 0, ADD, 0, 5'd0, ACT, 0);

        @(negedge clk);
        #1;
        n_assert++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
